// File: rtl/mem_arbiter.sv
// Two-port (core / external loader) arbiter in front of a single-port data RAM.
// Burst-limited ownership with alternating priority, 1-cycle read response routing.
module mem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, CORE_OWN, EXT_OWN} state_t;

  localparam logic [3:0] MAX_B = 4'(MAX_BURST);

  state_t     state, state_next;
  logic [3:0] burst_cnt, burst_next;
  logic       last_winner, last_next;  // 1 = ext won most recently
  logic       grant_core, grant_ext;
  logic       core_pend, ext_pend;

  // Grants are gated by reset so outputs drop the instant reset asserts.
  always_comb begin
    grant_core = 1'b0;
    grant_ext  = 1'b0;
    case (state)
      IDLE: begin
        if (core_req && ext_req) begin
          grant_core = last_winner;
          grant_ext  = !last_winner;
        end else begin
          grant_core = core_req;
          grant_ext  = ext_req;
        end
      end
      CORE_OWN: begin
        if (core_req && !(ext_req && burst_cnt == MAX_B)) grant_core = 1'b1;
        else                                              grant_ext  = ext_req;
      end
      EXT_OWN: begin
        if (ext_req && !(core_req && burst_cnt == MAX_B)) grant_ext  = 1'b1;
        else                                              grant_core = core_req;
      end
      default: ;
    endcase
    if (!reset) begin
      grant_core = 1'b0;
      grant_ext  = 1'b0;
    end
  end

  always_comb begin
    state_next = IDLE;
    burst_next = '0;
    last_next  = last_winner;
    if (grant_core) begin
      state_next = CORE_OWN;
      last_next  = 1'b0;
      if (state != CORE_OWN)    burst_next = 4'd1;
      else if (burst_cnt == MAX_B) burst_next = burst_cnt;
      else                      burst_next = burst_cnt + 4'd1;
    end else if (grant_ext) begin
      state_next = EXT_OWN;
      last_next  = 1'b1;
      if (state != EXT_OWN)     burst_next = 4'd1;
      else if (burst_cnt == MAX_B) burst_next = burst_cnt;
      else                      burst_next = burst_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      burst_cnt   <= '0;
      last_winner <= 1'b1;
      core_pend   <= 1'b0;
      ext_pend    <= 1'b0;
    end else begin
      state       <= state_next;
      burst_cnt   <= burst_next;
      last_winner <= last_next;
      core_pend   <= grant_core && !core_we;
      ext_pend    <= grant_ext && !ext_we;
    end
  end

  assign core_gnt = grant_core;
  assign ext_gnt  = grant_ext;
  assign mem_en   = grant_core || grant_ext;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant_core) begin
      mem_we    = core_we;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end else if (grant_ext) begin
      mem_we    = ext_we;
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
    end
  end

  assign core_rvalid = core_pend;
  assign ext_rvalid  = ext_pend;
  assign core_rdata  = core_pend ? mem_rdata : '0;
  assign ext_rdata   = ext_pend  ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, burst alternation, read/write routing,
// back-to-back reads across owners, reset during a read, burst limit.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_req, core_we, ext_req, ext_we;
  logic [31:0] core_addr, core_wdata, ext_addr, ext_wdata;
  logic        core_gnt, core_rvalid, ext_gnt, ext_rvalid;
  logic [31:0] core_rdata, ext_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int vectors = 0;
  int errors  = 0;

  logic [31:0] ram [16] = '{4: 32'hDEAD_BEEF, default: 32'h0};

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: read data appears the cycle after a read strobe.
  always @(posedge clk) begin
    if (mem_en && mem_we)  ram[mem_addr[5:2]] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= ram[mem_addr[5:2]];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    core_req = 1'b1; ext_req = 1'b1; core_we = 1'b0; ext_we = 1'b0;
    core_addr = 32'h10; ext_addr = 32'h4; core_wdata = '0; ext_wdata = '0;
    #1;
    vectors++;
    if ({core_gnt, ext_gnt} !== 2'b00) begin
      errors++; $display("FAIL reset_gnt: got %b expected 00", {core_gnt, ext_gnt});
    end
    step();
    vectors++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
      errors++; $display("FAIL reset_mem: got en=%b we=%b addr=%h wdata=%h expected all 0",
                         mem_en, mem_we, mem_addr, mem_wdata);
    end
    vectors++;
    if ({core_rvalid, ext_rvalid, core_rdata, ext_rdata} !== '0) begin
      errors++; $display("FAIL reset_resp: got rv=%b%b rdata=%h/%h expected 0",
                         core_rvalid, ext_rvalid, core_rdata, ext_rdata);
    end
    vectors++;
    if (dut.burst_cnt !== 4'd0) begin
      errors++; $display("FAIL reset_burst: got %0d expected 0", dut.burst_cnt);
    end
  endtask

  // Both requesting from reset release: core x4, ext x4, core x4.
  task automatic test_round_robin();
    logic exp_c, exp_e, prev_c, prev_e;
    prev_c = 1'b0; prev_e = 1'b0;
    reset = 1'b1;
    #1;
    for (int i = 0; i < 12; i++) begin
      exp_c = ((i / 4) % 2) == 0;
      exp_e = !exp_c;
      vectors++;
      if ({core_gnt, ext_gnt} !== {exp_c, exp_e}) begin
        errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", i, {core_gnt, ext_gnt}, {exp_c, exp_e});
      end
      vectors++;
      if ({core_rvalid, ext_rvalid} !== {prev_c, prev_e}) begin
        errors++; $display("FAIL rr_rvalid[%0d]: got %b expected %b", i, {core_rvalid, ext_rvalid}, {prev_c, prev_e});
      end
      prev_c = exp_c; prev_e = exp_e;
      step();
    end
    core_req = 1'b0; ext_req = 1'b0;
    #1;
    vectors++;
    if ({core_rvalid, ext_rvalid} !== 2'b10) begin
      errors++; $display("FAIL rr_last_rvalid: got %b expected 10", {core_rvalid, ext_rvalid});
    end
    step();
  endtask

  task automatic test_core_read();
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h0000_0010;
    #1;
    vectors++;
    if ({core_gnt, ext_gnt, mem_en, mem_we, mem_addr} !== {4'b1010, 32'h10}) begin
      errors++; $display("FAIL core_rd_req: got gnt=%b%b en=%b we=%b addr=%h expected 10 1 0 00000010",
                         core_gnt, ext_gnt, mem_en, mem_we, mem_addr);
    end
    step();
    core_req = 1'b0;
    #1;
    vectors++;
    if ({core_rvalid, ext_rvalid, core_rdata} !== {2'b10, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL core_rd_resp: got rv=%b%b rdata=%h expected 10 deadbeef",
                         core_rvalid, ext_rvalid, core_rdata);
    end
    step();
    vectors++;
    if ({core_rvalid, core_rdata} !== '0) begin
      errors++; $display("FAIL core_rd_after: got rv=%b rdata=%h expected 0", core_rvalid, core_rdata);
    end
  endtask

  task automatic test_ext_write();
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h0000_0004; ext_wdata = 32'h1234_5678;
    #1;
    vectors++;
    if ({ext_gnt, core_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {4'b1011, 32'h4, 32'h1234_5678}) begin
      errors++; $display("FAIL ext_wr_req: got gnt=%b%b en=%b we=%b addr=%h wdata=%h expected 10 1 1 00000004 12345678",
                         ext_gnt, core_gnt, mem_en, mem_we, mem_addr, mem_wdata);
    end
    step();
    ext_req = 1'b0; ext_we = 1'b0;
    #1;
    vectors++;
    if ({core_rvalid, ext_rvalid} !== 2'b00) begin
      errors++; $display("FAIL ext_wr_norv: got %b expected 00", {core_rvalid, ext_rvalid});
    end
    step();
  endtask

  // Core reads 0x4 (just written), ext reads 0x10 the next cycle.
  task automatic test_back_to_back();
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h4;
    #1;
    vectors++;
    if (core_gnt !== 1'b1) begin
      errors++; $display("FAIL b2b_core_gnt: got %b expected 1", core_gnt);
    end
    step();
    core_req = 1'b0;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h10;
    #1;
    vectors++;
    if ({ext_gnt, core_rvalid, ext_rvalid, core_rdata} !== {3'b110, 32'h1234_5678}) begin
      errors++; $display("FAIL b2b_n1: got gnt=%b rv=%b%b rdata=%h expected 1 10 12345678",
                         ext_gnt, core_rvalid, ext_rvalid, core_rdata);
    end
    step();
    ext_req = 1'b0;
    #1;
    vectors++;
    if ({core_rvalid, ext_rvalid, ext_rdata, core_rdata} !== {2'b01, 32'hDEAD_BEEF, 32'h0}) begin
      errors++; $display("FAIL b2b_n2: got rv=%b%b ext_rdata=%h core_rdata=%h expected 01 deadbeef 0",
                         core_rvalid, ext_rvalid, ext_rdata, core_rdata);
    end
    step();
  endtask

  task automatic test_reset_midread();
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h10;
    #1;
    vectors++;
    if (core_gnt !== 1'b1) begin
      errors++; $display("FAIL rst_mid_gnt: got %b expected 1", core_gnt);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if ({core_gnt, ext_gnt, mem_en, mem_we, mem_addr, core_rvalid, ext_rvalid} !== '0) begin
      errors++; $display("FAIL rst_mid_async: got gnt=%b%b en=%b addr=%h rv=%b%b expected 0",
                         core_gnt, ext_gnt, mem_en, mem_addr, core_rvalid, ext_rvalid);
    end
    step();
    core_req = 1'b0;
    reset = 1'b1;
    step();
    vectors++;
    if ({core_rvalid, ext_rvalid} !== 2'b00) begin
      errors++; $display("FAIL rst_mid_norv: got %b expected 00", {core_rvalid, ext_rvalid});
    end
    vectors++;
    if (dut.burst_cnt !== 4'd0) begin
      errors++; $display("FAIL rst_mid_burst: got %0d expected 0", dut.burst_cnt);
    end
  endtask

  // Ext alone from cycle 0, core joins at 3: ext 0-3, core 4-7, ext 8-9.
  task automatic test_burst_limit();
    logic [1:0] exp_g [10] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10,
                               2'b10, 2'b10, 2'b10, 2'b01, 2'b01};
    ext_we = 1'b0; core_we = 1'b0; ext_addr = 32'h8; core_addr = 32'hC;
    for (int i = 0; i < 10; i++) begin
      ext_req  = 1'b1;
      core_req = (i >= 3);
      #1;
      vectors++;
      if ({core_gnt, ext_gnt} !== exp_g[i]) begin
        errors++; $display("FAIL burst_gnt[%0d]: got %b expected %b", i, {core_gnt, ext_gnt}, exp_g[i]);
      end
      step();
    end
    core_req = 1'b0; ext_req = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_core_read();
    test_ext_write();
    test_back_to_back();
    test_reset_midread();
    test_burst_limit();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
